// File: rtl/qcw_adc_sampler.sv
// rtl/qcw_adc_sampler.sv - free-running serial front end for a 10-bit 16-SCLK current-sense ADC
module qcw_adc_sampler #(
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       adc_enable,
  input  logic       adc_sdata,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [9:0] adc_dout,
  output logic       adc_valid,
  output logic       adc_err
);

  // Divider counts 0..CLK_DIV-1; quiet counter covers the QUIET cycles that follow DONE.
  localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int QMAX  = (QUIET_CYCLES > 2) ? QUIET_CYCLES - 2 : 0;
  localparam int QW    = (QMAX > 1) ? $clog2(QMAX + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(QMAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_e;

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [QW-1:0] quiet_q;
  logic [3:0]    bit_q;
  logic [15:0]   sr_q;
  logic          cs_n_q;
  logic          sclk_q;
  logic [9:0]    dout_q;
  logic          valid_q;
  logic          err_q;

  // Frame sequencer: all outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= '0;
      quiet_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (adc_enable) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            div_q   <= '0;
          end
        end
        SETUP: begin
          if (div_q == DIV_LAST) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              // End of low phase: data is stable, capture it as sclk rises.
              sclk_q <= 1'b1;
              sr_q   <= {sr_q[14:0], adc_sdata};
            end else if (bit_q == 4'd15) begin
              state_q <= DONE;
              cs_n_q  <= 1'b1;
              if (sr_q[15:13] == 3'b000) begin
                dout_q  <= sr_q[12:3];
                valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              bit_q  <= bit_q + 1'b1;
              sclk_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        DONE: begin
          // DONE itself counts as the first quiet cycle.
          if (QUIET_CYCLES <= 1) begin
            state_q <= adc_enable ? SETUP : IDLE;
            cs_n_q  <= !adc_enable;
            div_q   <= '0;
          end else begin
            state_q <= QUIET;
            quiet_q <= '0;
          end
        end
        QUIET: begin
          if (quiet_q == Q_LAST) begin
            state_q <= adc_enable ? SETUP : IDLE;
            cs_n_q  <= !adc_enable;
            div_q   <= '0;
            quiet_q <= '0;
          end else begin
            quiet_q <= quiet_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
        end
      endcase
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc_dout  = dout_q;
  assign adc_valid = valid_q;
  assign adc_err   = err_q;

endmodule

// File: tb/tb_qcw_adc_sampler.sv
// tb/tb_qcw_adc_sampler.sv - scoreboard bench for qcw_adc_sampler with a serial ADC model
module tb_qcw_adc_sampler;

  logic       clk;
  logic       resetn;
  logic       adc_enable;
  logic       adc_sdata;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [9:0] adc_dout;
  logic       adc_valid;
  logic       adc_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [9:0] dout;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];

  qcw_adc_sampler #(.CLK_DIV(4), .QUIET_CYCLES(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .adc_enable (adc_enable),
    .adc_sdata  (adc_sdata),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_dout   (adc_dout),
    .adc_valid  (adc_valid),
    .adc_err    (adc_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC model: load a word at CS fall, present one bit MSB-first after each SCLK fall.
  logic [15:0] cur_word = 16'h0;
  int          bit_idx  = 15;
  always @(negedge adc_cs_n) begin
    cur_word = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0;
    bit_idx  = 15;
  end
  always @(negedge adc_sclk) begin
    if (!adc_cs_n && bit_idx >= 0) begin
      adc_sdata = cur_word[bit_idx];
      bit_idx   = bit_idx - 1;
    end
  end

  // Monitor: frame-length/edge counters and scoreboard compare on each strobe.
  int  cyc         = 0;
  int  cs_cnt      = 0;
  int  falls       = 0;
  int  last_strobe = 0;
  int  period;
  bit  prev_sclk   = 1'b1;
  bit  prev_strobe = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!resetn) begin
      cs_cnt = 0;
      falls  = 0;
    end else begin
      if (!adc_cs_n) cs_cnt = cs_cnt + 1;
      if (prev_sclk && !adc_sclk) falls = falls + 1;
      if (prev_strobe) begin
        checks++;
        assert ((adc_valid | adc_err) === 1'b0)
          else begin errors++; $error("FAIL strobe_width observed=%b expected=0", adc_valid | adc_err); end
      end
      if (adc_valid || adc_err) begin
        checks++;
        assert ((adc_valid & adc_err) === 1'b0)
          else begin errors++; $error("FAIL valid_err_excl observed=1 expected=0"); end
        checks++;
        assert (exp_q.size() > 0)
          else begin errors++; $error("FAIL unexpected_strobe observed valid=%b err=%b expected none", adc_valid, adc_err); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (adc_err === e.is_err)
            else begin errors++; $error("FAIL strobe_kind observed err=%b expected err=%b", adc_err, e.is_err); end
          checks++;
          assert (adc_dout === e.dout)
            else begin errors++; $error("FAIL dout observed=%h expected=%h", adc_dout, e.dout); end
        end
        checks++;
        assert (cs_cnt === 132)
          else begin errors++; $error("FAIL cs_low_len observed=%0d expected=132", cs_cnt); end
        checks++;
        assert (falls === 16)
          else begin errors++; $error("FAIL sclk_falls observed=%0d expected=16", falls); end
        checks++;
        assert (adc_cs_n === 1'b1)
          else begin errors++; $error("FAIL cs_at_strobe observed=%b expected=1", adc_cs_n); end
        period = cyc - last_strobe;
        if (last_strobe != 0 && period < 200) begin
          checks++;
          assert (period === 140)
            else begin errors++; $error("FAIL strobe_period observed=%0d expected=140", period); end
        end
        last_strobe = cyc;
        cs_cnt      = 0;
        falls       = 0;
      end
    end
    prev_sclk   = adc_sclk;
    prev_strobe = adc_valid | adc_err;
  end

  task automatic push_frame(input logic [2:0] lead, input logic [9:0] data, input logic [2:0] trail,
                            input bit is_err, input logic [9:0] exp_dout);
    exp_t x;
    frame_q.push_back({lead, data, trail});
    x.is_err = is_err;
    x.dout   = exp_dout;
    exp_q.push_back(x);
  endtask

  task automatic wait_exp_left(input int n, input int max_cyc, input string tag);
    int k = 0;
    while (exp_q.size() > n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    checks++;
    assert (exp_q.size() <= n)
      else begin errors++; $error("FAIL %s_timeout observed=%0d pending expected<=%0d", tag, exp_q.size(), n); end
  endtask

  task automatic wait_falls(input int n, input int max_cyc, input string tag);
    int k = 0;
    while (falls < n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    checks++;
    assert (falls >= n)
      else begin errors++; $error("FAIL %s_timeout observed=%0d falls expected>=%0d", tag, falls, n); end
  endtask

  int bad;

  initial begin
    resetn     = 1'b0;
    adc_enable = 1'b1;
    adc_sdata  = 1'b0;

    // Reset held with enable high: outputs at reset values, no SCLK activity.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (adc_sclk !== 1'b1 || adc_cs_n !== 1'b1) bad++;
    end
    checks++;
    assert (adc_cs_n === 1'b1) else begin errors++; $error("FAIL rst_cs_n observed=%b expected=1", adc_cs_n); end
    checks++;
    assert (adc_sclk === 1'b1) else begin errors++; $error("FAIL rst_sclk observed=%b expected=1", adc_sclk); end
    checks++;
    assert (adc_dout === 10'h000) else begin errors++; $error("FAIL rst_dout observed=%h expected=000", adc_dout); end
    checks++;
    assert (adc_valid === 1'b0) else begin errors++; $error("FAIL rst_valid observed=%b expected=0", adc_valid); end
    checks++;
    assert (adc_err === 1'b0) else begin errors++; $error("FAIL rst_err observed=%b expected=0", adc_err); end
    checks++;
    assert (bad === 0) else begin errors++; $error("FAIL rst_quiet_bus observed=%0d expected=0", bad); end

    // Continuous frames: 2A5, framing error (dout holds), 000, 3FF back to back, then 155 with enable drop.
    push_frame(3'b000, 10'h2A5, 3'b000, 1'b0, 10'h2A5);
    push_frame(3'b010, 10'h0F0, 3'b000, 1'b1, 10'h2A5);
    push_frame(3'b000, 10'h000, 3'b111, 1'b0, 10'h000);
    push_frame(3'b000, 10'h3FF, 3'b101, 1'b0, 10'h3FF);
    push_frame(3'b000, 10'h155, 3'b010, 1'b0, 10'h155);
    @(posedge clk); #2;
    resetn = 1'b1;

    wait_exp_left(1, 800, "frames_1_4");
    wait_falls(8, 200, "sclk_period_8");
    adc_enable = 1'b0;
    wait_exp_left(0, 200, "frame_5");

    // After the last frame completes with enable low, the bus stays idle.
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || adc_valid !== 1'b0 || adc_err !== 1'b0) bad++;
    end
    checks++;
    assert (bad === 0) else begin errors++; $error("FAIL idle_after_disable observed=%0d expected=0", bad); end
    checks++;
    assert (adc_dout === 10'h155) else begin errors++; $error("FAIL dout_hold observed=%h expected=155", adc_dout); end

    // Reset mid-frame: the aborted frame gets no expectation; the following frame must be clean.
    frame_q.push_back({3'b000, 10'h3C3, 3'b000});
    push_frame(3'b000, 10'h0AA, 3'b000, 1'b0, 10'h0AA);
    adc_enable = 1'b1;
    wait_falls(10, 300, "sclk_period_10");
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    checks++;
    assert (adc_cs_n === 1'b1) else begin errors++; $error("FAIL abort_cs_n observed=%b expected=1", adc_cs_n); end
    checks++;
    assert (adc_sclk === 1'b1) else begin errors++; $error("FAIL abort_sclk observed=%b expected=1", adc_sclk); end
    checks++;
    assert (adc_dout === 10'h000) else begin errors++; $error("FAIL abort_dout observed=%h expected=000", adc_dout); end
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    resetn = 1'b1;
    wait_exp_left(0, 400, "post_reset_frame");
    repeat (20) @(negedge clk);
    checks++;
    assert (adc_dout === 10'h0AA) else begin errors++; $error("FAIL final_dout observed=%h expected=0AA", adc_dout); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
